// File: rtl/n2_com_dp_32x72_fifo_ctl_pkg.sv
// Shared geometry for the 32x72 register-file FIFO controller and its output buffer.
package n2_com_dp_32x72_fifo_ctl_pkg;
    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_WIDTH = 72;
    localparam int PTR_W      = 5;
    localparam int CNT_W      = 6;
    localparam int BUF_W      = 2;
endpackage

// File: rtl/n2_com_dp_32x72_fifo_ctl_skid2.sv
// Two-entry in-order output buffer: captures array read data, presents the head
// to the pop stream, and clears on flush.
module n2_com_fifo_skid2
    import n2_com_dp_32x72_fifo_ctl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  cap,
    input  logic [FIFO_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic [BUF_W-1:0]      buf_cnt,
    output logic                  vld,
    output logic [FIFO_WIDTH-1:0] head_data
);
    logic [BUF_W-1:0]      buf_cnt_q, buf_cnt_d;
    logic [FIFO_WIDTH-1:0] ent0_q, ent0_d;
    logic [FIFO_WIDTH-1:0] ent1_q, ent1_d;
    logic                  pop_s;

    // Next-state for the two entries and the occupancy.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        buf_cnt_d = buf_cnt_q;
        pop_s     = pop & (buf_cnt_q != 2'd0);
        if (reset | clr) begin
            buf_cnt_d = 2'd0;
        end else begin
            case ({pop_s, cap})
                2'b01: begin
                    if (buf_cnt_q == 2'd0) begin
                        ent0_d = cap_data;
                    end else begin
                        ent1_d = cap_data;
                    end
                    buf_cnt_d = buf_cnt_q + 2'd1;
                end
                2'b10: begin
                    ent0_d    = ent1_q;
                    buf_cnt_d = buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (buf_cnt_q == 2'd1) begin
                        ent0_d = cap_data;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = cap_data;
                    end
                end
                default: buf_cnt_d = buf_cnt_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt_q <= 2'd0;
        end else begin
            buf_cnt_q <= buf_cnt_d;
        end
    end

    // Payload registers; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign buf_cnt   = buf_cnt_q;
    assign vld       = (buf_cnt_q != 2'd0);
    assign head_data = ent0_q;
endmodule

// File: rtl/n2_com_dp_32x72_fifo_ctl.sv
// FIFO controller for a 32x72 two-port register file: owns pointers, occupancy and
// read prefetch into a 2-entry output buffer for full-throughput pops.
module n2_com_dp_32x72_fifo_ctl
    import n2_com_dp_32x72_fifo_ctl_pkg::*;
#(
    parameter int AFULL_THR = 28
) (
    input  logic                  l2clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_vld,
    output logic                  push_rdy,
    input  logic [FIFO_WIDTH-1:0] push_data,
    output logic                  pop_vld,
    input  logic                  pop_rdy,
    output logic [FIFO_WIDTH-1:0] pop_data,
    output logic                  arr_wr_en,
    output logic [PTR_W-1:0]      arr_wr_adr,
    output logic [FIFO_WIDTH-1:0] arr_din,
    output logic                  arr_rd_en,
    output logic [PTR_W-1:0]      arr_rd_adr,
    input  logic [FIFO_WIDTH-1:0] arr_dout,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             almost_full_q, almost_full_d;
    logic             push_rdy_s, push_fire_s, pop_fire_s, credit_s, rd_fire_s;
    logic [BUF_W-1:0] buf_cnt_s;
    logic             pop_vld_s;

    // Handshakes, read credit and next state for pointers and occupancy.
    always_comb begin
        push_rdy_s  = (count_q != CNT_W'(FIFO_DEPTH)) & ~flush & ~reset;
        push_fire_s = push_vld & push_rdy_s;
        pop_fire_s  = pop_vld_s & pop_rdy;
        // Buffered plus in-flight words, less the one leaving, must leave room for one more.
        credit_s    = ({1'b0, buf_cnt_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_fire_s});
        rd_fire_s   = (count_q != {CNT_W{1'b0}}) & ~flush & ~reset & credit_s;
        inflight_d  = rd_fire_s;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (reset | flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_d = wr_ptr_q + 5'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_fire_s) begin
                rd_ptr_d = rd_ptr_q + 5'd1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_fire_s, rd_fire_s})
                2'b10:   count_d = count_q + 6'd1;
                2'b01:   count_d = count_q - 6'd1;
                default: count_d = count_q;
            endcase
        end
        almost_full_d = (count_d >= CNT_W'(AFULL_THR));
    end

    // Controller state registers.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            inflight_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            almost_full_q <= almost_full_d;
        end
    end

    n2_com_fifo_skid2 u_skid (
        .clk       (l2clk),
        .reset     (reset),
        .clr       (flush),
        .cap       (inflight_q),
        .cap_data  (arr_dout),
        .pop       (pop_rdy),
        .buf_cnt   (buf_cnt_s),
        .vld       (pop_vld_s),
        .head_data (pop_data)
    );

    assign push_rdy    = push_rdy_s;
    assign arr_wr_en   = push_fire_s;
    assign arr_wr_adr  = push_fire_s ? wr_ptr_q : {PTR_W{1'b0}};
    assign arr_din     = push_data;
    assign arr_rd_en   = rd_fire_s;
    assign arr_rd_adr  = rd_fire_s ? rd_ptr_q : {PTR_W{1'b0}};
    assign pop_vld     = pop_vld_s;
    assign count       = count_q;
    assign almost_full = almost_full_q;
endmodule

// File: tb/tb_n2_com_dp_32x72_fifo_ctl.sv
// Directed bench for the 32x72 FIFO controller with a behavioural array model.
module tb_n2_com_dp_32x72_fifo_ctl;
    logic        l2clk = 1'b0;
    logic        reset, flush, push_vld, push_rdy, pop_vld, pop_rdy;
    logic [71:0] push_data, pop_data, arr_din, arr_dout;
    logic        arr_wr_en, arr_rd_en, almost_full;
    logic [4:0]  arr_wr_adr, arr_rd_adr;
    logic [5:0]  count;
    logic [71:0] mem [0:31];
    int          checks = 0;
    int          failures = 0;

    always #5 l2clk = ~l2clk;

    n2_com_dp_32x72_fifo_ctl #(.AFULL_THR(28)) dut (
        .l2clk(l2clk), .reset(reset), .flush(flush),
        .push_vld(push_vld), .push_rdy(push_rdy), .push_data(push_data),
        .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_data(pop_data),
        .arr_wr_en(arr_wr_en), .arr_wr_adr(arr_wr_adr), .arr_din(arr_din),
        .arr_rd_en(arr_rd_en), .arr_rd_adr(arr_rd_adr), .arr_dout(arr_dout),
        .count(count), .almost_full(almost_full)
    );

    // Two-port register file: write at the edge, registered read data.
    always @(posedge l2clk) begin
        if (arr_wr_en) mem[arr_wr_adr] <= arr_din;
        if (arr_rd_en) arr_dout <= mem[arr_rd_adr];
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge l2clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pop_vld"}, pop_vld, 72'd0);
        chk({tag, "_count"}, count, 72'd0);
        chk({tag, "_afull"}, almost_full, 72'd0);
        chk({tag, "_wr_en"}, arr_wr_en, 72'd0);
        chk({tag, "_rd_en"}, arr_rd_en, 72'd0);
        chk({tag, "_wr_adr"}, arr_wr_adr, 72'd0);
        chk({tag, "_rd_adr"}, arr_rd_adr, 72'd0);
        chk({tag, "_push_rdy"}, push_rdy, 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int nxt, exp, pushed, popped, bubbles, wwrap, rwrap, npop, rd_bad, buf_bad;
        bit started, seen27, seen28;

        // Power-on reset with a push attempted
        reset = 1'b1; flush = 1'b0; push_vld = 1'b1; push_data = 72'd0; pop_rdy = 1'b0;
        step(); step(); settle();
        chk_reset_vals("por");
        reset = 1'b0; push_vld = 1'b0; settle();
        chk("por_push_rdy_after", push_rdy, 72'd1);

        // Single push latency
        push_vld = 1'b1; push_data = 72'h0_DEAD_BEEF; settle();
        chk("single_wr_en", arr_wr_en, 72'd1);
        chk("single_wr_adr", arr_wr_adr, 72'd0);
        step(); push_vld = 1'b0; settle();
        chk("single_rd_en_c1", arr_rd_en, 72'd1);
        chk("single_rd_adr_c1", arr_rd_adr, 72'd0);
        chk("single_count_c1", count, 72'd1);
        step(); settle();
        chk("single_rd_en_c2", arr_rd_en, 72'd0);
        chk("single_pop_vld_c2", pop_vld, 72'd0);
        chk("single_count_c2", count, 72'd0);
        step(); settle();
        chk("single_pop_vld_c3", pop_vld, 72'd1);
        chk("single_pop_data_c3", pop_data, 72'h0_DEAD_BEEF);
        pop_rdy = 1'b1; step(); pop_rdy = 1'b0; settle();
        chk("single_empty_after", pop_vld, 72'd0);

        // Fill to 34 with pop stalled
        nxt = 0; seen27 = 1'b0; seen28 = 1'b0; push_vld = 1'b1;
        for (int c = 0; c < 100 && nxt < 34; c++) begin
            push_data = 72'(nxt); settle();
            if (count == 6'd27 && !seen27) begin chk("afull_at27", almost_full, 72'd0); seen27 = 1'b1; end
            if (count == 6'd28 && !seen28) begin chk("afull_at28", almost_full, 72'd1); seen28 = 1'b1; end
            if (push_rdy) nxt++;
            step();
        end
        push_data = 72'd34; settle();
        chk("fill_accepted", nxt, 72'd34);
        chk("fill_seen28", seen28, 72'd1);
        chk("fill_push_rdy", push_rdy, 72'd0);
        chk("fill_count", count, 72'd32);
        chk("fill_afull", almost_full, 72'd1);
        chk("fill_pop_vld", pop_vld, 72'd1);
        push_vld = 1'b0; pop_rdy = 1'b1; exp = 0;
        for (int c = 0; c < 200 && exp < 34; c++) begin
            settle();
            if (pop_vld) begin chk("fill_pop_data", pop_data, 72'(exp)); exp++; end
            step();
        end
        pop_rdy = 1'b0; settle();
        chk("fill_pop_total", exp, 72'd34);
        chk("fill_drained_vld", pop_vld, 72'd0);
        chk("fill_drained_count", count, 72'd0);

        // Continuous streaming, 100 values
        pushed = 0; popped = 0; bubbles = 0; wwrap = 0; rwrap = 0; started = 1'b0; pop_rdy = 1'b1;
        for (int c = 0; c < 400 && popped < 100; c++) begin
            push_vld = (pushed < 100); push_data = 72'h1000 + 72'(pushed); settle();
            if (push_vld && push_rdy) pushed++;
            if (arr_wr_en && arr_wr_adr == 5'd31) wwrap++;
            if (arr_rd_en && arr_rd_adr == 5'd31) rwrap++;
            if (pop_vld) begin
                chk("stream_data", pop_data, 72'h1000 + 72'(popped));
                popped++; started = 1'b1;
            end else if (started) begin
                bubbles++;
            end
            step();
        end
        push_vld = 1'b0; pop_rdy = 1'b0;
        chk("stream_total", popped, 72'd100);
        chk("stream_bubbles", bubbles, 72'd0);
        chk("stream_wr_wraps", wwrap, 72'd3);
        chk("stream_rd_wraps", rwrap, 72'd3);

        // Flush with a read in flight
        nxt = 0; push_vld = 1'b1;
        for (int c = 0; c < 20 && nxt < 8; c++) begin
            push_data = 72'h200 + 72'(nxt); settle();
            if (push_rdy) nxt++;
            step();
        end
        push_vld = 1'b0;
        for (int c = 0; c < 5; c++) step();
        settle();
        chk("prefl_count", count, 72'd6);
        chk("prefl_head", pop_data, 72'h200);
        pop_rdy = 1'b1; settle();
        chk("prefl_rd_en", arr_rd_en, 72'd1);
        step();
        pop_rdy = 1'b0; flush = 1'b1; push_vld = 1'b1; push_data = 72'hBAD; settle();
        chk("flush_count_before", count, 72'd5);
        chk("flush_push_rdy", push_rdy, 72'd0);
        chk("flush_wr_en", arr_wr_en, 72'd0);
        chk("flush_rd_en", arr_rd_en, 72'd0);
        step();
        flush = 1'b0; push_vld = 1'b0; settle();
        chk("flush_pop_vld", pop_vld, 72'd0);
        chk("flush_count", count, 72'd0);
        for (int c = 0; c < 4; c++) begin
            step(); settle();
            chk("flush_no_stale", pop_vld, 72'd0);
        end
        push_vld = 1'b1; push_data = 72'h7; settle();
        chk("post_flush_push_rdy", push_rdy, 72'd1);
        step();
        push_vld = 1'b0; pop_rdy = 1'b1; npop = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (pop_vld) begin chk("post_flush_data", pop_data, 72'h7); npop++; end
            step();
        end
        pop_rdy = 1'b0;
        chk("post_flush_pops", npop, 72'd1);

        // Random pop stalls, 200 values
        pushed = 0; popped = 0; rd_bad = 0; buf_bad = 0;
        for (int c = 0; c < 3000 && popped < 200; c++) begin
            push_vld = (pushed < 200); push_data = 72'h3000 + 72'(pushed);
            pop_rdy = 1'($urandom_range(0, 1)); settle();
            if (arr_rd_en && count == 6'd0) rd_bad++;
            if (dut.buf_cnt_s > 2'd2) buf_bad++;
            if (push_vld && push_rdy) pushed++;
            if (pop_vld && pop_rdy) begin
                chk("rand_data", pop_data, 72'h3000 + 72'(popped));
                popped++;
            end
            step();
        end
        push_vld = 1'b0; pop_rdy = 1'b0;
        chk("rand_total", popped, 72'd200);
        chk("rand_rd_when_empty", rd_bad, 72'd0);
        chk("rand_buf_over", buf_bad, 72'd0);

        // Reset mid-stream with 10 queued
        nxt = 0; push_vld = 1'b1;
        for (int c = 0; c < 30 && nxt < 10; c++) begin
            push_data = 72'h400 + 72'(nxt); settle();
            if (push_rdy) nxt++;
            step();
        end
        push_vld = 1'b0;
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("mid_count", count, 72'd8);
        chk("mid_pop_vld", pop_vld, 72'd1);
        reset = 1'b1; push_vld = 1'b1; push_data = 72'h55;
        step(); step(); settle();
        chk_reset_vals("mid");
        reset = 1'b0; push_vld = 1'b0; settle();
        chk("mid_push_rdy_after", push_rdy, 72'd1);
        for (int c = 0; c < 3; c++) begin
            step(); settle();
            chk("mid_empty_vld", pop_vld, 72'd0);
            chk("mid_empty_count", count, 72'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
